// File: rtl/bist_pkg.sv
// Shared types and constants for the scan-BIST signature checker.
// Holds the controller state encoding, default sizes and width helpers.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        UNLOAD,
        COMPARE,
        DONE_S
    } state_t;

    localparam int CHAIN_LEN_DEF = 8;
    localparam int NUM_PAT_DEF   = 16;
    localparam int SIG_W_DEF     = 16;

    localparam logic [SIG_W_DEF-1:0] GOLDEN_DEF = 16'hA5C3;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bist_sig_collector.sv
// Serial signature collector: shifts SIGN in MSB-first and compares to GOLDEN.
// Ports: clk, rst_n, clr, shift_en, cmp_en, sign -> sig[SIG_W], pass.
module bist_sig_collector
    import bist_pkg::*;
#(
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(GOLDEN_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             cmp_en,
    input  logic             sign,
    output logic [SIG_W-1:0] sig,
    output logic             pass
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig  <= '0;
            pass <= 1'b0;
        end else if (clr) begin
            sig  <= '0;
            pass <= 1'b0;
        end else begin
            // First sampled bit travels up to the MSB.
            if (shift_en)
                sig <= {sig[SIG_W-2:0], sign};
            if (cmp_en)
                pass <= (sig == GOLDEN);
        end
    end

endmodule

// File: rtl/bist_signature_checker.sv
// BIST controller: sequences shift/capture, unloads the MISR, checks signature.
// Ports: CLK, RST (async low), START, SIGN -> SE, TEST_RST, BUSY, DONE, PASS, SIG_OUT, PAT_CNT.
module bist_signature_checker
    import bist_pkg::*;
#(
    parameter int               CHAIN_LEN    = CHAIN_LEN_DEF,
    parameter int               NUM_PATTERNS = NUM_PAT_DEF,
    parameter int               SIG_W        = SIG_W_DEF,
    parameter logic [SIG_W-1:0] GOLDEN       = SIG_W'(GOLDEN_DEF)
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                START,
    input  logic                                SIGN,
    output logic                                SE,
    output logic                                TEST_RST,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                PASS,
    output logic [SIG_W-1:0]                    SIG_OUT,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   PAT_CNT
);

    localparam int SW = cnt_w(CHAIN_LEN);
    localparam int UW = cnt_w(SIG_W);
    localparam int PW = cnt_w(NUM_PATTERNS);

    localparam logic [SW-1:0] SH_LAST  = SW'(CHAIN_LEN - 1);
    localparam logic [UW-1:0] UN_LAST  = UW'(SIG_W - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS);

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] sh_cnt;
    logic [UW-1:0] un_cnt;

    logic se_d;
    logic trst_d;
    logic busy_d;
    logic done_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (START) next_state = INIT;
            INIT:    next_state = SHIFT;
            SHIFT:   if (sh_cnt == SH_LAST) next_state = CAPTURE;
            CAPTURE: next_state = (PAT_CNT == PAT_LAST) ? UNLOAD : SHIFT;
            UNLOAD:  if (un_cnt == UN_LAST) next_state = COMPARE;
            COMPARE: next_state = DONE_S;
            DONE_S:  if (START) next_state = INIT;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so each
    // registered output lines up with the state it belongs to.
    always_comb begin
        se_d   = (next_state == SHIFT) || (next_state == UNLOAD);
        trst_d = (next_state == INIT);
        busy_d = (next_state != IDLE) && (next_state != DONE_S);
        done_d = (next_state == DONE_S);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SE       <= 1'b0;
            TEST_RST <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            SE       <= se_d;
            TEST_RST <= trst_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
        end
    end

    // Counters restart at zero whenever their state is (re)entered and
    // never advance past their terminal count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_cnt  <= '0;
            un_cnt  <= '0;
            PAT_CNT <= '0;
        end else begin
            if (state == SHIFT && next_state == SHIFT)
                sh_cnt <= sh_cnt + SW'(1);
            else
                sh_cnt <= '0;

            if (state == UNLOAD && next_state == UNLOAD)
                un_cnt <= un_cnt + UW'(1);
            else
                un_cnt <= '0;

            if (next_state == INIT)
                PAT_CNT <= '0;
            else if (next_state == CAPTURE)
                PAT_CNT <= PAT_CNT + PW'(1);
        end
    end

    bist_sig_collector #(
        .SIG_W  (SIG_W),
        .GOLDEN (GOLDEN)
    ) u_collector (
        .clk      (CLK),
        .rst_n    (RST),
        .clr      (next_state == INIT),
        .shift_en (state == UNLOAD),
        .cmp_en   (state == COMPARE),
        .sign     (SIGN),
        .sig      (SIG_OUT),
        .pass     (PASS)
    );

endmodule

// File: tb/tb_bist_signature_checker.sv
// Scoreboard bench for bist_signature_checker.
// Small (2/3/4) instance for sequencing and abort; default instance for back-to-back runs.
module tb_bist_signature_checker;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
        logic [7:0]  pat;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic se;
        logic trst;
    } seq_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    logic       s_start = 1'b0;
    logic       s_sign  = 1'b0;
    logic       s_se, s_trst, s_busy, s_done, s_pass;
    logic [3:0] s_sig;
    logic [1:0] s_pat;

    logic        b_start = 1'b0;
    logic        b_sign  = 1'b0;
    logic        b_se, b_trst, b_busy, b_done, b_pass;
    logic [15:0] b_sig;
    logic [4:0]  b_pat;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t sb_s[$];
    exp_t sb_b[$];
    seq_t seq_q[$];
    logic seq_en = 1'b0;

    logic [14:0] se_pat = 15'b011011011011110;
    logic [3:0]  s_bits = 4'b0000;
    int          s_idx  = 0;
    logic [15:0] b_words [3];
    int          b_run  = 0;
    int          b_idx  = 0;

    bist_signature_checker #(
        .CHAIN_LEN    (2),
        .NUM_PATTERNS (3),
        .SIG_W        (4),
        .GOLDEN       (4'hB)
    ) u_small (
        .CLK      (CLK),
        .RST      (RST),
        .START    (s_start),
        .SIGN     (s_sign),
        .SE       (s_se),
        .TEST_RST (s_trst),
        .BUSY     (s_busy),
        .DONE     (s_done),
        .PASS     (s_pass),
        .SIG_OUT  (s_sig),
        .PAT_CNT  (s_pat)
    );

    bist_signature_checker u_big (
        .CLK      (CLK),
        .RST      (RST),
        .START    (b_start),
        .SIGN     (b_sign),
        .SE       (b_se),
        .TEST_RST (b_trst),
        .BUSY     (b_busy),
        .DONE     (b_done),
        .PASS     (b_pass),
        .SIG_OUT  (b_sig),
        .PAT_CNT  (b_pat)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // SIGN drivers: present one bit per UNLOAD cycle, MSB first.
    initial forever begin
        @(negedge CLK);
        if (s_se && s_pat == 2'd3) begin
            s_sign = s_bits[3 - s_idx];
            s_idx  = (s_idx == 3) ? 0 : s_idx + 1;
        end else begin
            s_idx = 0;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (b_se && b_pat == 5'd16 && b_run < 3) begin
            b_sign = b_words[b_run][15 - b_idx];
            b_idx++;
            if (b_idx == 16) begin
                b_idx = 0;
                b_run++;
            end
        end
    end

    // Result monitors: pop on each rising DONE.
    initial begin : mon_small
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (s_done && !prev) begin
                check("s_done_expected", 32'(sb_s.size() != 0), 1);
                if (sb_s.size() != 0) begin
                    e = sb_s.pop_front();
                    check("s_done_cycle", cyc, e.cyc);
                    check("s_sig_out", 32'(s_sig), 32'(e.sig));
                    check("s_pass", 32'(s_pass), 32'(e.pass));
                    check("s_pat_cnt", 32'(s_pat), 32'(e.pat));
                    check("s_busy_low", 32'(s_busy), 0);
                end
            end
            prev = s_done;
        end
    end

    initial begin : mon_big
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (b_done && !prev) begin
                check("b_done_expected", 32'(sb_b.size() != 0), 1);
                if (sb_b.size() != 0) begin
                    e = sb_b.pop_front();
                    check("b_done_cycle", cyc, e.cyc);
                    check("b_sig_out", 32'(b_sig), 32'(e.sig));
                    check("b_pass", 32'(b_pass), 32'(e.pass));
                    check("b_pat_cnt", 32'(b_pat), 32'(e.pat));
                end
            end
            prev = b_done;
        end
    end

    // Per-cycle SE / TEST_RST sequence monitor for the small instance.
    initial begin : mon_seq
        seq_t q;
        forever begin
            @(negedge CLK);
            if (seq_en) begin
                if (s_busy) begin
                    check("seq_expected", 32'(seq_q.size() != 0), 1);
                    if (seq_q.size() != 0) begin
                        q = seq_q.pop_front();
                        check("se_seq", 32'(s_se), 32'(q.se));
                        check("test_rst_seq", 32'(s_trst), 32'(q.trst));
                    end
                end else begin
                    check("test_rst_idle", 32'(s_trst), 0);
                    check("se_idle", 32'(s_se), 0);
                end
            end
        end
    end

    // Called at a negedge; START is sampled on the following posedge.
    task automatic start_small(input logic [3:0] bits,
                               input logic [3:0] esig,
                               input logic       epass);
        exp_t e;
        seq_t q;
        s_bits = bits;
        e.sig  = 16'(esig);
        e.pass = epass;
        e.pat  = 8'd3;
        e.cyc  = cyc + 1 + 15;
        sb_s.push_back(e);
        if (seq_en) begin
            for (int i = 0; i < 15; i++) begin
                q.se   = se_pat[14 - i];
                q.trst = (i == 0);
                seq_q.push_back(q);
            end
        end
        s_start = 1'b1;
        @(negedge CLK);
        s_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_s.size() + sb_b.size() + seq_q.size()) != 0
               && n < budget) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        check("drain", 32'(sb_s.size() + sb_b.size() + seq_q.size()), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t e;

        // Reset state of both instances.
        repeat (2) @(negedge CLK);
        check("rst_s_se", 32'(s_se), 0);
        check("rst_s_trst", 32'(s_trst), 0);
        check("rst_s_busy", 32'(s_busy), 0);
        check("rst_s_done", 32'(s_done), 0);
        check("rst_s_pass", 32'(s_pass), 0);
        check("rst_s_sig", 32'(s_sig), 0);
        check("rst_s_pat", 32'(s_pat), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        check("rst_b_sig", 32'(b_sig), 0);
        check("rst_b_pat", 32'(b_pat), 0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_no_start", 32'(s_busy), 0);

        // Tests 1/2: SE/TEST_RST sequence, latency, passing signature.
        seq_en = 1'b1;
        start_small(4'b1011, 4'hB, 1'b1);
        wait_drain(40);

        // Test 3: wrong signature.
        start_small(4'b1010, 4'hA, 1'b0);
        wait_drain(40);

        // Test 4: START during SHIFT of pattern 2 is ignored.
        start_small(4'b1011, 4'hB, 1'b1);
        for (int n = 0; n < 40 && !(s_se && s_pat == 2'd1); n++)
            @(negedge CLK);
        check("t4_in_shift2", 32'(s_se && s_pat == 2'd1), 1);
        s_start = 1'b1;
        @(negedge CLK);
        s_start = 1'b0;
        wait_drain(40);
        repeat (20) @(negedge CLK);
        check("t4_still_done", 32'(s_done), 1);

        // Test 5: asynchronous abort in UNLOAD.
        seq_en = 1'b0;
        start_small(4'b1011, 4'hB, 1'b1);
        for (int n = 0; n < 40 && !(s_se && s_pat == 2'd3); n++)
            @(negedge CLK);
        check("t5_in_unload", 32'(s_se && s_pat == 2'd3), 1);
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("abort_se", 32'(s_se), 0);
        check("abort_busy", 32'(s_busy), 0);
        check("abort_done", 32'(s_done), 0);
        check("abort_pass", 32'(s_pass), 0);
        check("abort_sig", 32'(s_sig), 0);
        check("abort_pat", 32'(s_pat), 0);
        sb_s.delete();
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_idle_busy", 32'(s_busy), 0);
        check("abort_idle_done", 32'(s_done), 0);
        seq_en = 1'b1;
        start_small(4'b1011, 4'hB, 1'b1);
        wait_drain(40);
        seq_en = 1'b0;

        // Test 6: default instance, START held 400 cycles -> 3 runs.
        b_words[0] = 16'hA5C3;
        b_words[1] = 16'hA5C2;
        b_words[2] = 16'hA5C3;
        b_run = 0;
        b_idx = 0;
        for (int k = 0; k < 3; k++) begin
            e.sig  = b_words[k];
            e.pass = (k != 1);
            e.pat  = 8'd16;
            e.cyc  = cyc + 1 + 162 + k * 163;
            sb_b.push_back(e);
        end
        b_start = 1'b1;
        repeat (400) @(negedge CLK);
        b_start = 1'b0;
        wait_drain(200);
        repeat (10) @(negedge CLK);
        check("b_final_done", 32'(b_done), 1);
        check("b_final_busy", 32'(b_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
